// File: rtl/hybrid_slave_rx.sv
// hybrid_slave_rx: dual-edge serial receiver, R channel on posedge and F channel on negedge,
// each deserialised LSB-first into a one-entry hold register with valid/read, overflow and count.
module hybrid_slave_rx #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sbda,
  input  logic          en_r,
  input  logic          en_f,
  input  logic          rd_r,
  input  logic          rd_f,
  input  logic          ovf_clr,
  output logic [DW-1:0] byte_r,
  output logic          vld_r,
  output logic [DW-1:0] byte_f,
  output logic          vld_f,
  output logic          ovf_r,
  output logic          ovf_f,
  output logic [CW-1:0] cnt_r,
  output logic [CW-1:0] cnt_f
);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST = BW'(DW - 1);
  typedef enum logic {IDLE, SHIFT} st_t;
  st_t st_r_q, st_r_d, st_f_q, st_f_d;
  logic [BW-1:0] bc_r_q, bc_r_d, bc_f_q, bc_f_d;
  logic [DW-1:0] sh_r_q, sh_r_d, sh_f_q, sh_f_d, stage_f_q, stage_f_d;
  logic [DW-1:0] hold_r_q, hold_r_d, hold_f_q, hold_f_d;
  logic tog_f_q, tog_f_d, tog_seen_q;
  logic vld_r_q, vld_r_d, vld_f_q, vld_f_d, ovf_r_q, ovf_r_d, ovf_f_q, ovf_f_d;
  logic [CW-1:0] cnt_r_q, cnt_r_d, cnt_f_q, cnt_f_d;
  logic done_r, done_f, xfer_f, acc_r, acc_f;
  always_comb begin
    done_r   = en_r && st_r_q == SHIFT && bc_r_q == LAST;
    st_r_d   = en_r ? SHIFT : IDLE;
    bc_r_d   = (!en_r || done_r) ? '0 : bc_r_q + BW'(1);
    sh_r_d   = en_r ? {sbda, sh_r_q[DW-1:1]} : sh_r_q;
    done_f   = en_f && st_f_q == SHIFT && bc_f_q == LAST;
    st_f_d   = en_f ? SHIFT : IDLE;
    bc_f_d   = (!en_f || done_f) ? '0 : bc_f_q + BW'(1);
    sh_f_d   = en_f ? {sbda, sh_f_q[DW-1:1]} : sh_f_q;
    stage_f_d = done_f ? sh_f_d : stage_f_q;
    tog_f_d  = tog_f_q ^ done_f;
  end
  // F completions reach the posedge domain as a toggle, so the stage is stable for a full cycle
  always_comb begin
    xfer_f   = tog_f_q ^ tog_seen_q;
    acc_r    = done_r && (!vld_r_q || rd_r);
    acc_f    = xfer_f && (!vld_f_q || rd_f);
    hold_r_d = acc_r ? sh_r_d : hold_r_q;
    hold_f_d = acc_f ? stage_f_q : hold_f_q;
    vld_r_d  = acc_r || (vld_r_q && !rd_r);
    vld_f_d  = acc_f || (vld_f_q && !rd_f);
    ovf_r_d  = (done_r && vld_r_q && !rd_r) || (ovf_r_q && !ovf_clr);
    ovf_f_d  = (xfer_f && vld_f_q && !rd_f) || (ovf_f_q && !ovf_clr);
    cnt_r_d  = cnt_r_q + CW'(acc_r);
    cnt_f_d  = cnt_f_q + CW'(acc_f);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r_q     <= IDLE;
      bc_r_q     <= '0;
      sh_r_q     <= '0;
      tog_seen_q <= 1'b0;
      hold_r_q   <= '0;
      hold_f_q   <= '0;
      vld_r_q    <= 1'b0;
      vld_f_q    <= 1'b0;
      ovf_r_q    <= 1'b0;
      ovf_f_q    <= 1'b0;
      cnt_r_q    <= '0;
      cnt_f_q    <= '0;
    end else begin
      st_r_q     <= st_r_d;
      bc_r_q     <= bc_r_d;
      sh_r_q     <= sh_r_d;
      tog_seen_q <= tog_f_q;
      hold_r_q   <= hold_r_d;
      hold_f_q   <= hold_f_d;
      vld_r_q    <= vld_r_d;
      vld_f_q    <= vld_f_d;
      ovf_r_q    <= ovf_r_d;
      ovf_f_q    <= ovf_f_d;
      cnt_r_q    <= cnt_r_d;
      cnt_f_q    <= cnt_f_d;
    end
  end
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_f_q    <= IDLE;
      bc_f_q    <= '0;
      sh_f_q    <= '0;
      stage_f_q <= '0;
      tog_f_q   <= 1'b0;
    end else begin
      st_f_q    <= st_f_d;
      bc_f_q    <= bc_f_d;
      sh_f_q    <= sh_f_d;
      stage_f_q <= stage_f_d;
      tog_f_q   <= tog_f_d;
    end
  end
  assign byte_r = hold_r_q;
  assign byte_f = hold_f_q;
  assign vld_r  = vld_r_q;
  assign vld_f  = vld_f_q;
  assign ovf_r  = ovf_r_q;
  assign ovf_f  = ovf_f_q;
  assign cnt_r  = cnt_r_q;
  assign cnt_f  = cnt_f_q;
endmodule
